// File: rtl/cmd_serializer.sv
// cmd_serializer: pops 16-bit FIFO command words and shifts them out MSB-first, one frame per 16 cycles, idle-filling gaps.
// Define CMD_SYNC_EN to send SYNC_WORD in frame 0 and every SYNC_INTERVAL-th frame after it.
module cmd_serializer #(
    parameter logic [15:0] IDLE_WORD     = 16'h6969,
    parameter logic [15:0] SYNC_WORD     = 16'h817E,
    parameter int          SYNC_INTERVAL = 32
) (
    input  logic        clk160,
    input  logic        rst,
    input  logic        cmd_empty,
    input  logic        cmd_valid,
    input  logic [15:0] cmd_data,
    output logic        rd_cmd,
    output logic        ser_out,
    output logic        frame_start,
    output logic [31:0] cmd_frames,
    output logic        ovf_err
);
    logic [3:0]  cnt;
    logic [15:0] shreg;
    logic [15:0] hold;
    logic [15:0] next_frame;
    logic        hold_vld;
    logic        sync_due;
    logic        frame_end;
    logic        consume;

`ifdef CMD_SYNC_EN
    logic [15:0] sync_cnt;
    // sync_cnt holds the index (mod SYNC_INTERVAL) of the frame loaded next
    assign sync_due = sync_cnt == 16'd0;
    always_ff @(posedge clk160) begin
        if (rst)
            sync_cnt <= '0;
        else if (frame_end)
            sync_cnt <= (sync_cnt == 16'(SYNC_INTERVAL - 1)) ? '0 : sync_cnt + 16'd1;
    end
`else
    logic unused_interval;
    assign sync_due = 1'b0;
    assign unused_interval = ^SYNC_INTERVAL;
`endif

    always_comb begin
        frame_end = cnt == 4'd15;
        consume = frame_end && hold_vld && !sync_due;
        next_frame = sync_due ? SYNC_WORD : hold_vld ? hold : IDLE_WORD;
    end

    assign ser_out = shreg[15];

    always_ff @(posedge clk160) begin
        if (rst) begin
            cnt <= 4'd15;
            shreg <= '0;
            rd_cmd <= 1'b0;
            frame_start <= 1'b0;
            hold <= '0;
            hold_vld <= 1'b0;
            cmd_frames <= '0;
            ovf_err <= 1'b0;
        end else begin
            cnt <= cnt + 4'd1;
            shreg <= frame_end ? next_frame : {shreg[14:0], 1'b0};
            frame_start <= frame_end;
            rd_cmd <= (cnt == 4'd12) && !cmd_empty && !hold_vld && !sync_due;
            if (cmd_valid) begin
                hold <= cmd_data;
                hold_vld <= 1'b1;
            end else if (consume) begin
                hold_vld <= 1'b0;
            end
            if (cmd_valid && hold_vld && !consume)
                ovf_err <= 1'b1;
            if (consume)
                cmd_frames <= cmd_frames + 32'd1;
        end
    end
endmodule

// File: doc/cmd_serializer.md
# cmd_serializer

Consumer end of the 40→160 MHz command word FIFO. Runs on clk160, pops 16-bit command words from the FIFO read port and serializes them MSB-first onto a 1-bit command line, one 16-bit frame every 16 cycles. When no command is available, it fills the line with an idle word. Optionally, it inserts a periodic sync word for link lock. The serial output feeds the emulated chip's command input.

## Interface

Parameters:
- IDLE_WORD, 16'h6969: frame sent when no command word is available.
- SYNC_WORD, 16'h817E: frame sent on sync slots (only with CMD_SYNC_EN).
- SYNC_INTERVAL, 32: frame period of sync insertion; legal range 2..65535.

Ports:
- clk160  in  1: serializer clock; FIFO read clock. Single clock; all logic is on its rising edge.
- rst  in  1: synchronous, active-high reset.
- cmd_empty  in  1: FIFO empty flag (read domain).
- cmd_valid  in  1: FIFO read data valid, one cycle after the accepted rd_cmd.
- cmd_data  in  16: FIFO read data, qualified by cmd_valid.
- rd_cmd  out  1: FIFO read enable; registered; one-cycle pulse.
- ser_out  out  1: serial command line; MSB first.
- frame_start  out  1: high during the cycle that ser_out carries bit 15 of a frame.
- cmd_frames  out  32: count of command frames sent; wraps.
- ovf_err  out  1: sticky; set when cmd_valid arrives while the hold register is full.

## Operation

- Registers:
  - cnt[3:0]: bit counter.
  - shreg[15:0]: shift register; ser_out = shreg[15], taken directly from the flop.
  - hold[15:0] and hold_vld.
  - sync_cnt[15:0]: frame counter for sync insertion.
- Reset values:
  - shreg = 0, so ser_out = 0.
  - cnt = 15.
  - rd_cmd = 0, frame_start = 0, hold_vld = 0, sync_cnt = 0, cmd_frames = 0, ovf_err = 0.
- Every edge when rst is low:
  - If cnt == 15: shreg <= next_frame, cnt <= 0.
  - Otherwise: shreg <= shreg << 1, cnt <= cnt + 1.
- next_frame priority:
  - SYNC_WORD if a sync is due (CMD_SYNC_EN only).
  - Else hold if hold_vld; then hold_vld <= 0 and cmd_frames increments.
  - Else IDLE_WORD.
- Fetch: rd_cmd <= (cnt == 12) && !cmd_empty && !hold_vld && !sync_due_next.
  - So rd_cmd is high during the cnt == 13 cycle.
  - cmd_valid arrives during the cnt == 14 cycle.
  - hold captures cmd_data on the edge ending cnt == 14.
- Capture: any cmd_valid loads hold and sets hold_vld.
  - If hold_vld is already set and not being consumed on the same edge, the new word overwrites hold and ovf_err is set.
- frame_start <= (cnt == 15); it stays high for one cycle per frame.
- At most one FIFO read per frame. rd_cmd is never asserted while cmd_empty is sampled high at cnt == 12.

## Timing

- Frame period: 16 clk160 cycles; the line is never idle-low between frames.
- First frame after reset:
  - The first edge with rst low loads frame 0.
  - ser_out shows bit 15 in the first cycle after that edge; frame_start is high in that same cycle.
- FIFO-to-line latency:
  - A word read at cnt == 13 of frame N is transmitted as frame N+1.
  - Its first bit appears 3 cycles after the rd_cmd cycle.
- Empty FIFO: IDLE_WORD frames repeat, with no rd_cmd pulses.
- A word written into an empty FIFO late in a frame is sent in the frame after the next fetch point it meets.
- Reset mid-frame: the frame is truncated and hold is dropped; after release, the outputs follow the reset rules above.
  - A FIFO word whose rd_cmd was already issued is lost. This is acceptable because the FIFO is reset together with the serializer.
- cmd_frames wraps from 32'hFFFFFFFF to 0.

## Configuration

- CMD_SYNC_EN defined:
  - Frame 0 after reset is SYNC_WORD.
  - After that, every SYNC_INTERVAL-th frame is SYNC_WORD, so sync frames sit at indices 0, SYNC_INTERVAL, 2·SYNC_INTERVAL, and so on.
  - sync_cnt counts frames modulo SYNC_INTERVAL; sync_due = (sync_cnt == 0).
  - No fetch is issued in the frame preceding a sync slot, and hold is preserved across the sync frame.
- CMD_SYNC_EN undefined:
  - No sync logic; SYNC_WORD and SYNC_INTERVAL are unused.
  - Frame 0 is IDLE_WORD or a command.

## Test plan

- Reset, FIFO empty for 5 frames → ser_out carries 16'h6969 ×5 (16'h817E first if CMD_SYNC_EN); rd_cmd stays 0; frame_start pulses every 16 cycles.
- FIFO holds 16'hA5C3 and 16'h1234 → exactly one rd_cmd per frame at cnt == 13; the next frames are A5C3 then 1234, then 6969; cmd_frames = 2.
- Continuous FIFO supply of 100 words (sync disabled) → 100 back-to-back command frames with no idle in between; cmd_frames = 100.
- CMD_SYNC_EN with SYNC_INTERVAL = 4 and a full FIFO → frames follow the pattern S,C,C,C,S,C,…; no rd_cmd in frames 3, 7, …; no command word lost or reordered.
- Inject a spurious cmd_valid at cnt == 5 with hold_vld set → ovf_err = 1 and stays set until rst.
- Assert rst at cnt == 7 of a command frame → next cycle: ser_out = 0, rd_cmd = 0, cmd_frames = 0, and the frame restarts as specified.
